frame_receiver: RTL
===================

# frame_receiver

RX-side counterpart of the delay-test frame generator: consumes the gig_eth_mac RX client interface, parses test frames, and computes per-frame one-way delay from the embedded transmit timestamp. It also reports the sequence number and keeps good/bad/lost/out-of-order/foreign frame statistics. It sits in nf_core between the port-1 MAC RX client outputs and the result/statistics consumers, in the rx_clk domain.

## Interface
- ETHERTYPE, 16'h88B5, EtherType identifying a test frame
- CNT_W, 32, width of every statistics counter
- rx_clk  in  1  MAC RX client clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- chk_en  in  1  enable; sampled only at frame start (first dvld byte)
- clear_stats  in  1  synchronous clear of all counters and sequence tracking
- cur_time  in  32  free-running local time, already in rx_clk domain
- mac_rx_data  in  8  RX byte (destination MAC first; no preamble/SFD)
- mac_rx_dvld  in  1  byte valid; contiguous high for one frame
- mac_rx_goodframe  in  1  one-cycle pulse: frame passed CRC/length checks
- mac_rx_badframe  in  1  one-cycle pulse: frame failed
- result_valid  out  1  one-cycle pulse per accepted test frame
- result_seq  out  32  sequence number of that frame
- result_delay  out  32  cur_time at byte 0 minus tx timestamp, mod 2^32
- good_cnt, bad_cnt, foreign_cnt, lost_cnt, ooo_cnt  out  CNT_W each  statistics

## Operation
- Frame layout (byte index from first dvld byte): 0-11 MACs (ignored), 12-13 EtherType, 14-17 sequence, 18-21 tx timestamp; all fields big-endian; bytes from 22 ignored.
- States: IDLE, HDR, DRAIN, STATUS, SKIP.
- IDLE: on dvld=1 capture cur_time into t_rx, byte_cnt=1; chk_en=1 -> HDR, else SKIP.
- HDR: shift bytes into ethertype/seq/ts registers per index; byte_cnt increments per dvld byte (saturates at 22). byte_cnt reaches 22 -> DRAIN. dvld falls before 22 bytes -> runt flag, STATUS.
- DRAIN: dvld falls -> STATUS.
- STATUS: waits for goodframe or badframe. A status pulse coincident with the last dvld byte is honoured (latched in HDR/DRAIN).
- Classification on status:
  - badframe -> bad_cnt++.
  - goodframe with runt or EtherType != ETHERTYPE -> foreign_cnt++.
  - Otherwise good_cnt++, result_valid, plus sequence check.
- Sequence check: first good frame after reset/clear sets expected=seq+1, no loss counted. Later frames take d = seq - expected (32-bit):
  - d=0: expected=seq+1.
  - d in [1, 2^31-1]: lost_cnt += d, expected=seq+1.
  - Otherwise: ooo_cnt++, expected unchanged.
- SKIP: ignores bytes and the status pulse, then returns to IDLE; no counters change.
- dvld rising in STATUS without status received: old frame counted bad_cnt++, new frame starts (t_rx captured, byte_cnt=1) same cycle.
- Counters wrap at 2^CNT_W except lost_cnt, which saturates at all-ones.
- clear_stats zeroes counters and sequence tracking; the frame in flight continues and is counted after the clear. reset has priority over clear_stats.

## Timing
- Reset values: result_valid=0, result_seq=0, result_delay=0, all counters 0, state IDLE, sequence tracking uninitialised.
- result_valid, result_seq, and result_delay are registered. They assert exactly 1 cycle after the goodframe pulse is sampled.
- result_seq and result_delay hold until the next result_valid.
- Counter updates are visible the same cycle as result_valid, or 1 cycle after a bad/foreign status.
- The block is always ready; no backpressure. Minimum inter-frame gap supported is 1 idle dvld cycle.
- Reset mid-frame: return to IDLE. Remaining bytes of that frame (dvld still high) are treated as SKIP until dvld falls and its status arrives.

## Test plan
- Good test frame: seq=0x00000005, ts=0x00001000, cur_time=0x00001234 at byte 0, 64 bytes, goodframe → result_valid 1 cycle later, result_seq=5, result_delay=0x234, good_cnt=1.
- Wrap-around: ts=0xFFFFFFF0, cur_time=0x00000010 → result_delay=0x20.
- Sequence 1, 2, 5, 3 → lost_cnt=2, ooo_cnt=1, good_cnt=4, expected=6 afterwards.
- Mixed frames:
  - badframe on valid test frame → bad_cnt=1, no result_valid.
  - EtherType 0x0800 goodframe → foreign_cnt=1.
  - 20-byte frame with goodframe → foreign_cnt=2.
- Timing edge cases:
  - goodframe coincident with last dvld byte → accepted normally.
  - new frame arrives before status → bad_cnt++ and second frame parsed correctly.
- reset asserted at byte 16 → outputs zero.
  - Remainder of that frame ignored.
  - Next good frame counts as first (lost_cnt=0).
  - chk_en=0 at frame start → no counter changes.

Source files
------------

// File: rtl/frame_receiver.sv
// frame_receiver
//   Receive side of the delay-test path. Parses test frames from the MAC RX
//   client interface and reports each accepted frame's sequence number and its
//   one-way delay (local time at byte 0 minus the embedded tx timestamp).
//   Also keeps good/bad/foreign/lost/out-of-order frame statistics.
//
// Ports
//   rx_clk            MAC RX client clock, all logic on the rising edge
//   reset             synchronous, active-high
//   chk_en            enable, looked at only on the first byte of a frame
//   clear_stats       zeroes the counters and the sequence tracking
//   cur_time[31:0]    free-running local time (rx_clk domain)
//   mac_rx_data[7:0]  RX byte, destination MAC first
//   mac_rx_dvld       byte valid, high for the whole frame
//   mac_rx_goodframe  one-cycle status pulse: frame passed the MAC checks
//   mac_rx_badframe   one-cycle status pulse: frame failed
//   result_valid      one-cycle pulse per accepted test frame
//   result_seq[31:0]  sequence number of that frame (held until next result)
//   result_delay[31:0] cur_time at byte 0 minus tx timestamp, mod 2^32
//   good_cnt, bad_cnt, foreign_cnt, lost_cnt, ooo_cnt [CNT_W-1:0] statistics
//
// Frame layout (byte index): 0-11 MACs, 12-13 EtherType, 14-17 sequence,
// 18-21 tx timestamp, all big-endian; everything after byte 21 is ignored.
module frame_receiver #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          CNT_W     = 32
) (
  input  logic             rx_clk,
  input  logic             reset,
  input  logic             chk_en,
  input  logic             clear_stats,
  input  logic [31:0]      cur_time,
  input  logic [7:0]       mac_rx_data,
  input  logic             mac_rx_dvld,
  input  logic             mac_rx_goodframe,
  input  logic             mac_rx_badframe,
  output logic             result_valid,
  output logic [31:0]      result_seq,
  output logic [31:0]      result_delay,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  output logic [CNT_W-1:0] foreign_cnt,
  output logic [CNT_W-1:0] lost_cnt,
  output logic [CNT_W-1:0] ooo_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DRAIN, S_STATUS, S_SKIP} state_t;

  localparam int SW = ((CNT_W > 32) ? CNT_W : 32) + 1;

  // Saturating add used for the lost-frame counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [31:0]      b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SW'({CNT_W{1'b1}})) sat_add = {CNT_W{1'b1}};
    else                        sat_add = s[CNT_W-1:0];
  endfunction

  state_t            r_state, w_state_nx;
  logic [4:0]        r_byte_cnt;
  logic [31:0]       r_t_rx;
  logic [15:0]       r_etype, w_etype_nx;
  logic [31:0]       r_seq, w_seq_nx;
  logic [31:0]       r_ts, w_ts_nx;
  logic              r_runt, r_done, r_dvld_d;
  logic [31:0]       r_exp_seq, w_exp_seq_nx;
  logic              r_exp_vld, w_exp_vld_nx;
  logic              r_res_vld, w_res_vld_nx;
  logic [31:0]       r_res_seq, r_res_delay;
  logic [CNT_W-1:0]  r_good, r_bad, r_foreign, r_lost, r_ooo;
  logic [CNT_W-1:0]  w_good_nx, w_bad_nx, w_foreign_nx, w_lost_nx, w_ooo_nx;

  logic        w_stat, w_good_st, w_rise, w_runt, w_foreign;
  logic        w_start, w_cls, w_done_set, w_done_clr, w_runt_set;
  logic [31:0] w_seq_d;

  assign w_stat    = mac_rx_goodframe | mac_rx_badframe;
  assign w_good_st = mac_rx_goodframe & ~mac_rx_badframe;
  assign w_rise    = mac_rx_dvld & ~r_dvld_d;

  // Header fields including the byte on the bus this cycle, so a status pulse
  // coincident with the last header byte classifies with complete fields.
  always_comb begin
    w_etype_nx = r_etype;
    w_seq_nx   = r_seq;
    w_ts_nx    = r_ts;
    if (r_state == S_HDR && mac_rx_dvld) begin
      if (r_byte_cnt == 5'd12 || r_byte_cnt == 5'd13)
        w_etype_nx = {r_etype[7:0], mac_rx_data};
      else if (r_byte_cnt >= 5'd14 && r_byte_cnt <= 5'd17)
        w_seq_nx = {r_seq[23:0], mac_rx_data};
      else if (r_byte_cnt >= 5'd18 && r_byte_cnt <= 5'd21)
        w_ts_nx = {r_ts[23:0], mac_rx_data};
    end
  end

  // Still in HDR at classification means fewer than 22 bytes arrived, unless
  // the current byte is byte 21.
  always_comb begin
    if (r_state == S_HDR) w_runt = mac_rx_dvld ? (r_byte_cnt < 5'd21) : 1'b1;
    else                  w_runt = r_runt;
  end
  assign w_foreign = w_runt | (w_etype_nx != ETHERTYPE);

  always_ff @(posedge rx_clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_cls      = 1'b0;
    w_done_set = 1'b0;
    w_done_clr = 1'b0;
    w_runt_set = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (mac_rx_dvld) begin
          // dvld already high last cycle: tail of a frame cut short by reset.
          if (r_dvld_d) begin
            w_state_nx = S_SKIP;
            w_done_clr = 1'b1;
          end else begin
            w_start    = 1'b1;
            w_state_nx = chk_en ? S_HDR : S_SKIP;
          end
        end
      end
      S_HDR: begin
        if (mac_rx_dvld) begin
          if (w_stat) begin
            w_cls      = 1'b1;
            w_done_set = 1'b1;
            w_state_nx = S_DRAIN;
          end else if (r_byte_cnt == 5'd21) begin
            w_state_nx = S_DRAIN;
          end
        end else begin
          w_runt_set = 1'b1;
          if (w_stat) begin
            w_cls      = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_STATUS;
          end
        end
      end
      S_DRAIN: begin
        // r_done: status already taken with the last byte; just wait for dvld low.
        if (r_done) begin
          if (!mac_rx_dvld) w_state_nx = S_IDLE;
        end else if (mac_rx_dvld) begin
          if (w_stat) begin
            w_cls      = 1'b1;
            w_done_set = 1'b1;
          end
        end else if (w_stat) begin
          w_cls      = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_STATUS;
        end
      end
      S_STATUS: begin
        // A new frame before any status closes the old one as bad.
        if (w_stat || mac_rx_dvld) w_cls = 1'b1;
        if (mac_rx_dvld) begin
          w_start    = 1'b1;
          w_state_nx = chk_en ? S_HDR : S_SKIP;
        end else if (w_stat) begin
          w_state_nx = S_IDLE;
        end
      end
      S_SKIP: begin
        if (w_rise) begin
          w_start    = 1'b1;
          w_state_nx = chk_en ? S_HDR : S_SKIP;
        end else if (!mac_rx_dvld && (w_stat || r_done)) begin
          w_state_nx = S_IDLE;
        end else if (w_stat) begin
          w_done_set = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Statistics and sequence tracking. A clear coinciding with a
  // classification clears first, then counts the frame.
  assign w_seq_d = w_seq_nx - r_exp_seq;

  always_comb begin
    w_good_nx    = clear_stats ? '0 : r_good;
    w_bad_nx     = clear_stats ? '0 : r_bad;
    w_foreign_nx = clear_stats ? '0 : r_foreign;
    w_lost_nx    = clear_stats ? '0 : r_lost;
    w_ooo_nx     = clear_stats ? '0 : r_ooo;
    w_exp_vld_nx = clear_stats ? 1'b0 : r_exp_vld;
    w_exp_seq_nx = r_exp_seq;
    w_res_vld_nx = 1'b0;
    if (w_cls) begin
      if (!w_good_st) begin
        w_bad_nx = w_bad_nx + CNT_W'(1);
      end else if (w_foreign) begin
        w_foreign_nx = w_foreign_nx + CNT_W'(1);
      end else begin
        w_good_nx    = w_good_nx + CNT_W'(1);
        w_res_vld_nx = 1'b1;
        if (!w_exp_vld_nx) begin
          w_exp_vld_nx = 1'b1;
          w_exp_seq_nx = w_seq_nx + 32'd1;
        end else if (w_seq_d == 32'd0) begin
          w_exp_seq_nx = w_seq_nx + 32'd1;
        end else if (!w_seq_d[31]) begin
          w_lost_nx    = sat_add(w_lost_nx, w_seq_d);
          w_exp_seq_nx = w_seq_nx + 32'd1;
        end else begin
          w_ooo_nx = w_ooo_nx + CNT_W'(1);
        end
      end
    end
  end

  // Header capture registers carry no reset; r_dvld_d is deliberately left
  // unreset so a frame still streaming after reset is recognised as a tail.
  always_ff @(posedge rx_clk) begin
    r_dvld_d <= mac_rx_dvld;
    r_etype  <= w_etype_nx;
    r_seq    <= w_seq_nx;
    r_ts     <= w_ts_nx;
    r_exp_seq <= w_exp_seq_nx;
    if (w_start) r_t_rx <= cur_time;
  end

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      r_byte_cnt  <= 5'd0;
      r_runt      <= 1'b0;
      r_done      <= 1'b0;
      r_exp_vld   <= 1'b0;
      r_res_vld   <= 1'b0;
      r_res_seq   <= 32'd0;
      r_res_delay <= 32'd0;
      r_good      <= '0;
      r_bad       <= '0;
      r_foreign   <= '0;
      r_lost      <= '0;
      r_ooo       <= '0;
    end else begin
      if (w_start)
        r_byte_cnt <= 5'd1;
      else if ((r_state == S_HDR || r_state == S_DRAIN) && mac_rx_dvld &&
               r_byte_cnt != 5'd22)
        r_byte_cnt <= r_byte_cnt + 5'd1;
      if (w_start)         r_runt <= 1'b0;
      else if (w_runt_set) r_runt <= 1'b1;
      if (w_start || w_done_clr) r_done <= 1'b0;
      else if (w_done_set)       r_done <= 1'b1;
      r_exp_vld <= w_exp_vld_nx;
      r_res_vld <= w_res_vld_nx;
      if (w_res_vld_nx) begin
        r_res_seq   <= w_seq_nx;
        r_res_delay <= r_t_rx - w_ts_nx;
      end
      r_good    <= w_good_nx;
      r_bad     <= w_bad_nx;
      r_foreign <= w_foreign_nx;
      r_lost    <= w_lost_nx;
      r_ooo     <= w_ooo_nx;
    end
  end

  assign result_valid = r_res_vld;
  assign result_seq   = r_res_seq;
  assign result_delay = r_res_delay;
  assign good_cnt     = r_good;
  assign bad_cnt      = r_bad;
  assign foreign_cnt  = r_foreign;
  assign lost_cnt     = r_lost;
  assign ooo_cnt      = r_ooo;

endmodule
